// File: rtl/nes_pad_poller.sv
// nes_pad_poller
// Console-side sequencer for up to two CD4021-style NES pads. It drives the
// shared latch and shift-clock strobes, samples both active-low serial lines,
// and publishes an atomically updated 16-bit pressed-button vector.
//
// Ports:
//   clk_i      system clock (rising edge)
//   rst_ni     asynchronous active-low reset
//   enable_i   automatic polling enable (does not gate start_i)
//   start_i    one-shot poll request, honoured in IDLE only
//   data_ni    serial data, pad p on bit p, active-low, asynchronous
//   latch_o    shared latch strobe, active-high
//   pad_clk_o  shared shift clock, idles low
//   buttons_o  pad p in [8p+7:8p] as {a,b,select,start,up,down,left,right}
//   valid_o    one-cycle pulse when buttons_o is updated
//   busy_o     poll sequence in progress
//
// state    | meaning
// ---------+----------------------------------------------------
// IDLE     | waiting for start_i or a pending auto-trigger
// LATCH_LO | latch high, pad clock low
// LATCH_HI | latch high, pad clock high (parallel load edge)
// BIT_LO   | pad clock low; sample bit i in the last tick cycle
// BIT_HI   | pad clock high; pads shift to the next bit
// DONE     | publish shadow to buttons_o, pulse valid_o
module nes_pad_poller #(
  parameter int unsigned CLK_DIV     = 64,
  parameter int unsigned POLL_PERIOD = 16384
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        enable_i,
  input  logic        start_i,
  input  logic [1:0]  data_ni,
  output logic        latch_o,
  output logic        pad_clk_o,
  output logic [15:0] buttons_o,
  output logic        valid_o,
  output logic        busy_o
);

  localparam int unsigned TW = $clog2(CLK_DIV);
  localparam int unsigned PW = $clog2(POLL_PERIOD + 1);
  localparam logic [TW-1:0] TICK_LAST   = TW'(CLK_DIV - 1);
  localparam logic [PW-1:0] PERIOD_LAST = PW'(POLL_PERIOD - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_LATCH_LO, S_LATCH_HI, S_BIT_LO, S_BIT_HI, S_DONE
  } state_e;

  state_e        state_q, state_d;
  logic [TW-1:0] tick_q, tick_d;
  logic [2:0]    bit_q, bit_d;
  logic [1:0]    sync1_q, sync2_q;
  logic [15:0]   shadow_q, shadow_d;
  logic [15:0]   buttons_q, buttons_d;
  logic [PW-1:0] period_q, period_d;
  logic          pend_q, pend_d;

  logic tick_end;
  logic start_poll;

  assign tick_end   = (tick_q == '0);
  assign start_poll = (state_q == S_IDLE) && (start_i || pend_q);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q   <= S_IDLE;
      tick_q    <= '0;
      bit_q     <= '0;
      sync1_q   <= '0;
      sync2_q   <= '0;
      shadow_q  <= '0;
      buttons_q <= '0;
      period_q  <= '0;
      pend_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      tick_q    <= tick_d;
      bit_q     <= bit_d;
      sync1_q   <= data_ni;
      sync2_q   <= sync1_q;
      shadow_q  <= shadow_d;
      buttons_q <= buttons_d;
      period_q  <= period_d;
      pend_q    <= pend_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    tick_d    = tick_q;
    bit_d     = bit_q;
    shadow_d  = shadow_q;
    buttons_d = buttons_q;

    unique case (state_q)
      S_IDLE: begin
        if (start_poll) begin
          state_d = S_LATCH_LO;
          tick_d  = TICK_LAST;
        end
      end
      S_LATCH_LO: begin
        if (tick_end) begin
          state_d = S_LATCH_HI;
          tick_d  = TICK_LAST;
        end else begin
          tick_d = tick_q - 1'b1;
        end
      end
      S_LATCH_HI: begin
        if (tick_end) begin
          state_d = S_BIT_LO;
          tick_d  = TICK_LAST;
          bit_d   = '0;
        end else begin
          tick_d = tick_q - 1'b1;
        end
      end
      S_BIT_LO: begin
        if (tick_end) begin
          // Bit i lands at position 7-i, which is ~i for a 3-bit index.
          shadow_d[{1'b0, ~bit_q}] = ~sync2_q[0];
          shadow_d[{1'b1, ~bit_q}] = ~sync2_q[1];
          tick_d = TICK_LAST;
          if (bit_q == 3'd7) begin
            // Load here so the new vector is visible during DONE with valid_o.
            state_d   = S_DONE;
            buttons_d = shadow_d;
          end else begin
            state_d = S_BIT_HI;
          end
        end else begin
          tick_d = tick_q - 1'b1;
        end
      end
      S_BIT_HI: begin
        if (tick_end) begin
          state_d = S_BIT_LO;
          tick_d  = TICK_LAST;
          bit_d   = bit_q + 1'b1;
        end else begin
          tick_d = tick_q - 1'b1;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Auto-trigger: a wrap in the same cycle as a poll start re-arms the flag,
  // since that wrap is a fresh trigger.
  always_comb begin
    period_d = period_q;
    pend_d   = pend_q;
    if (!enable_i) begin
      period_d = '0;
      pend_d   = 1'b0;
    end else begin
      if (start_poll) begin
        pend_d = 1'b0;
      end
      if (period_q == PERIOD_LAST) begin
        period_d = '0;
        pend_d   = 1'b1;
      end else begin
        period_d = period_q + 1'b1;
      end
    end
  end

  assign latch_o   = (state_q == S_LATCH_LO) || (state_q == S_LATCH_HI);
  assign pad_clk_o = (state_q == S_LATCH_HI) || (state_q == S_BIT_HI);
  assign valid_o   = (state_q == S_DONE);
  assign busy_o    = (state_q != S_IDLE);
  assign buttons_o = buttons_q;

endmodule

// File: tb/tb_nes_pad_poller.sv
`timescale 1ns/1ps
module tb_nes_pad_poller;

  logic        clk;
  logic        rst_n;
  logic        enable_a, start_a;
  logic [1:0]  data_a;
  logic        latch_a, pad_clk_a, valid_a, busy_a;
  logic [15:0] buttons_a;
  logic        enable_b, start_b;
  logic [1:0]  data_b;
  logic        latch_b, pad_clk_b, valid_b, busy_b;
  logic [15:0] buttons_b;

  int checks = 0;
  int errors = 0;

  // pad model: parallel load on a clock rise while latch is high, else shift
  logic [7:0] load0, load1, sr0, sr1;

  nes_pad_poller #(.CLK_DIV(4), .POLL_PERIOD(200)) dut_a (
    .clk_i(clk), .rst_ni(rst_n), .enable_i(enable_a), .start_i(start_a),
    .data_ni(data_a), .latch_o(latch_a), .pad_clk_o(pad_clk_a),
    .buttons_o(buttons_a), .valid_o(valid_a), .busy_o(busy_a)
  );

  nes_pad_poller #(.CLK_DIV(4), .POLL_PERIOD(10)) dut_b (
    .clk_i(clk), .rst_ni(rst_n), .enable_i(enable_b), .start_i(start_b),
    .data_ni(data_b), .latch_o(latch_b), .pad_clk_o(pad_clk_b),
    .buttons_o(buttons_b), .valid_o(valid_b), .busy_o(busy_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    sr0 = 8'hFF;
    sr1 = 8'hFF;
  end

  always @(posedge pad_clk_a) begin
    sr0 <= latch_a ? load0 : {sr0[6:0], 1'b1};
    sr1 <= latch_a ? load1 : {sr1[6:0], 1'b1};
  end

  assign data_a = {sr1[7], sr0[7]};

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic test_reset();
    rst_n = 1'b0;
    enable_a = 1'b0; start_a = 1'b0;
    enable_b = 1'b0; start_b = 1'b0;
    data_b = 2'b11;
    load0 = 8'hFF; load1 = 8'hFF;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (5) @(negedge clk);
    checks++;
    if ({latch_a, pad_clk_a, valid_a, busy_a} !== 4'b0000) begin
      errors++;
      $display("FAIL reset_ctrl: got %b want 0000", {latch_a, pad_clk_a, valid_a, busy_a});
    end
    checks++;
    if (buttons_a !== 16'h0000) begin
      errors++;
      $display("FAIL reset_buttons: got %h want 0000", buttons_a);
    end
  endtask

  // Start one poll at cycle N and check every cycle N+1..N+72 against the
  // hand-derived strobe schedule for CLK_DIV=4.
  task automatic run_poll(input string name, input logic [7:0] l0, input logic [7:0] l1,
                          input logic [15:0] prev, input logic [15:0] exp);
    int rises;
    int s;
    logic pc_prev;
    logic exp_latch, exp_pc;
    load0 = l0;
    load1 = l1;
    rises = 0;
    pc_prev = 1'b0;
    @(negedge clk);
    start_a = 1'b1;
    for (int k = 1; k <= 72; k++) begin
      @(negedge clk);
      if (k == 1) start_a = 1'b0;
      s = (k - 1) / 4;
      exp_latch = (k <= 8);
      exp_pc = (k <= 68) && ((s == 1) || ((s >= 3) && (s % 2 == 1)));
      if (pad_clk_a && !pc_prev) rises++;
      pc_prev = pad_clk_a;
      checks++;
      if (latch_a !== exp_latch) begin
        errors++;
        $display("FAIL %s latch k=%0d: got %b want %b", name, k, latch_a, exp_latch);
      end
      checks++;
      if (pad_clk_a !== exp_pc) begin
        errors++;
        $display("FAIL %s pad_clk k=%0d: got %b want %b", name, k, pad_clk_a, exp_pc);
      end
      checks++;
      if (busy_a !== (k <= 69)) begin
        errors++;
        $display("FAIL %s busy k=%0d: got %b want %b", name, k, busy_a, (k <= 69));
      end
      checks++;
      if (valid_a !== (k == 69)) begin
        errors++;
        $display("FAIL %s valid k=%0d: got %b want %b", name, k, valid_a, (k == 69));
      end
      checks++;
      if (buttons_a !== ((k >= 69) ? exp : prev)) begin
        errors++;
        $display("FAIL %s buttons k=%0d: got %h want %h", name, k, buttons_a,
                 (k >= 69) ? exp : prev);
      end
    end
    checks++;
    if (rises != 8) begin
      errors++;
      $display("FAIL %s pad_clk_rises: got %0d want 8", name, rises);
    end
  endtask

  task automatic test_basic();
    run_poll("basic", 8'b0111_1110, 8'hFF, 16'h0000, 16'h0081);
  endtask

  task automatic test_pad1_start();
    run_poll("pad1_start", 8'hFF, 8'b1110_1111, 16'h0081, 16'h1000);
  endtask

  task automatic test_change();
    run_poll("change1", 8'h7F, 8'hFF, 16'h1000, 16'h0080);
    run_poll("change2", 8'hFE, 8'hFF, 16'h0080, 16'h0001);
  endtask

  task automatic test_auto();
    int vt[5];
    int nv;
    nv = 0;
    @(negedge clk);
    enable_a = 1'b1;
    for (int k = 1; k <= 1300 && nv < 5; k++) begin
      @(negedge clk);
      if (valid_a) begin
        vt[nv] = k;
        nv++;
      end
      // stray requests only while busy; they must not add polls
      start_a = busy_a && (k % 50 == 7);
    end
    start_a = 1'b0;
    checks++;
    if (nv != 5) begin
      errors++;
      $display("FAIL auto_count: got %0d pulses want 5", nv);
    end
    for (int i = 1; i < nv; i++) begin
      checks++;
      if (vt[i] - vt[i-1] != 200) begin
        errors++;
        $display("FAIL auto_period %0d: got %0d want 200", i, vt[i] - vt[i-1]);
      end
    end
    enable_a = 1'b0;
    for (int k = 0; k < 100 && busy_a; k++) @(negedge clk);
    checks++;
    if (busy_a !== 1'b0) begin
      errors++;
      $display("FAIL auto_stop: busy got %b want 0", busy_a);
    end
  endtask

  task automatic test_reset_midpoll();
    run_poll("pre_reset", 8'b0111_1110, 8'hFF, 16'h0001, 16'h0081);
    @(negedge clk);
    start_a = 1'b1;
    for (int k = 1; k <= 30; k++) begin
      @(negedge clk);
      if (k == 1) start_a = 1'b0;
    end
    checks++;
    if (busy_a !== 1'b1) begin
      errors++;
      $display("FAIL midpoll_busy: got %b want 1", busy_a);
    end
    rst_n = 1'b0;
    #1;
    checks++;
    if ({latch_a, pad_clk_a, valid_a, busy_a} !== 4'b0000) begin
      errors++;
      $display("FAIL midpoll_reset_ctrl: got %b want 0000", {latch_a, pad_clk_a, valid_a, busy_a});
    end
    checks++;
    if (buttons_a !== 16'h0000) begin
      errors++;
      $display("FAIL midpoll_reset_buttons: got %h want 0000", buttons_a);
    end
    @(negedge clk);
    rst_n = 1'b1;
    for (int k = 1; k <= 100; k++) begin
      @(negedge clk);
      checks++;
      if ({latch_a, pad_clk_a, valid_a, busy_a} !== 4'b0000 || buttons_a !== 16'h0000) begin
        errors++;
        $display("FAIL post_reset_idle k=%0d: got ctrl %b buttons %h want 0000/0000", k,
                 {latch_a, pad_clk_a, valid_a, busy_a}, buttons_a);
      end
    end
  endtask

  task automatic test_back_to_back();
    int last_v, last_done, nv;
    logic lprev;
    last_v = -1;
    last_done = -1;
    nv = 0;
    lprev = 1'b0;
    @(negedge clk);
    enable_b = 1'b1;
    for (int k = 1; k <= 400; k++) begin
      @(negedge clk);
      if (latch_b && !lprev && last_done >= 0) begin
        checks++;
        if (k != last_done + 2) begin
          errors++;
          $display("FAIL b2b_gap: latch rise at %0d want %0d", k, last_done + 2);
        end
      end
      lprev = latch_b;
      if (valid_b) begin
        if (last_v >= 0) begin
          checks++;
          if (k - last_v != 70) begin
            errors++;
            $display("FAIL b2b_period: got %0d want 70", k - last_v);
          end
        end
        last_v = k;
        last_done = k;
        nv++;
      end
    end
    checks++;
    if (nv < 5) begin
      errors++;
      $display("FAIL b2b_count: got %0d polls want at least 5", nv);
    end
    checks++;
    if (buttons_b !== 16'h0000) begin
      errors++;
      $display("FAIL b2b_buttons: got %h want 0000", buttons_b);
    end
    enable_b = 1'b0;
  endtask

  initial begin
    test_reset();
    test_basic();
    test_pad1_start();
    test_change();
    test_auto();
    test_reset_midpoll();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
